// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if: start/done multiply handshake bundle.
// Ports carried: start, is_signed, operand1, operand2 (requester -> unit); busy, done, hi, lo (unit -> requester).
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, is_signed, operand1, operand2, input busy, done, hi, lo);
    modport slave  (input start, is_signed, operand1, operand2, output busy, done, hi, lo);
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-2 Booth multiplier, one step per clock, signed/unsigned per operation.
// Ports: clock, reset (sync, active-high); bus (slave) carries start/is_signed/operands in, busy/done/hi/lo out.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    booth_mult_seq_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int W1 = WIDTH + 1;
    localparam int PW = 2 * W1 + 2;
    localparam int CW = $clog2(WIDTH + 2);
    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [W1:0]      r_m;
    logic [PW-1:0]    r_p;
    logic             r_done;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic [W1-1:0]    w_ext1, w_ext2;
    logic [W1:0]      w_upper;
    logic [PW-1:0]    w_shift;
    logic             w_accept, w_last;
    // One extra operand bit lets a single signed datapath handle unsigned operands via zero extension.
    always_comb begin
        w_ext1      = {bus.is_signed & bus.operand1[WIDTH-1], bus.operand1};
        w_ext2      = {bus.is_signed & bus.operand2[WIDTH-1], bus.operand2};
        w_upper     = r_p[1:0] == 2'b01 ? r_p[PW-1:W1+1] + r_m :
                      r_p[1:0] == 2'b10 ? r_p[PW-1:W1+1] - r_m : r_p[PW-1:W1+1];
        w_shift     = {w_upper[W1], w_upper, r_p[W1:1]};
        w_accept    = r_state == IDLE && bus.start;
        w_last      = r_state == RUN && r_cnt == CW'(W1 - 1);
        w_state_nxt = w_accept ? RUN : w_last ? IDLE : r_state;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_m     <= '0;
            r_p     <= '0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if (w_accept) begin
                r_p   <= {{(W1 + 1){1'b0}}, w_ext2, 1'b0};
                r_m   <= {w_ext1[W1-1], w_ext1};
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_p   <= w_shift;
                r_cnt <= r_cnt + CW'(1);
            end
            // The final step's shifted value already holds the product in bits [2*W1:1].
            if (w_last) begin
                r_hi <= w_shift[2*WIDTH:WIDTH+1];
                r_lo <= w_shift[WIDTH:1];
            end
        end
    end
    assign bus.busy = r_state == RUN;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and randomized checks of booth_mult_seq at WIDTH 32 and 8.
module tb_booth_mult_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clock = ~clock;
    booth_mult_seq_if #(.WIDTH(32)) bus32();
    booth_mult_seq_if #(.WIDTH(8))  bus8();
    booth_mult_seq #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32.slave));
    booth_mult_seq #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus32.start = 1'b1; bus32.is_signed = sgn; bus32.operand1 = a; bus32.operand2 = b;
        @(negedge clock);
        bus32.start = 1'b0;
    endtask

    task automatic wait32(output int lat);
        lat = 0;
        while (!bus32.done && lat < 200) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic mul32(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        int lat;
        go32(sgn, a, b);
        wait32(lat);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_hi"}, 64'(bus32.hi), 64'(eh));
        check({tag, "_lo"}, 64'(bus32.lo), 64'(el));
        @(negedge clock);
        check({tag, "_pulse"}, 64'(bus32.done), 64'd0);
    endtask

    task automatic mul8(input string tag, input logic sgn, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ep);
        int lat;
        @(negedge clock);
        bus8.start = 1'b1; bus8.is_signed = sgn; bus8.operand1 = a; bus8.operand2 = b;
        @(negedge clock);
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd9);
        check({tag, "_prod"}, 64'({bus8.hi, bus8.lo}), 64'(ep));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nd;
        logic [7:0]  a8, b8;
        logic [15:0] ref8;
        bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.operand1 = '0; bus32.operand2 = '0;
        bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.operand1  = '0; bus8.operand2  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", 64'(bus32.busy), 64'd0);
        check("rst_done", 64'(bus32.done), 64'd0);
        check("rst_hi",   64'(bus32.hi),   64'd0);
        check("rst_lo",   64'(bus32.lo),   64'd0);

        mul32("s7xm3",   1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        mul32("u_ff_ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        mul32("s_ff_ff", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        mul32("s_min2",  1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        mul32("s_maxmin",1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
        mul32("u_big",   1'b0, 32'h80000000, 32'h00000003, 32'h00000001, 32'h80000000);

        go32(1'b1, 32'd5, 32'd6);
        repeat (4) @(negedge clock);
        bus32.start = 1'b1; bus32.operand1 = 32'd100; bus32.operand2 = 32'd100;
        @(negedge clock);
        bus32.start = 1'b0;
        wait32(lat);
        check("busy_ign_lat", 64'(lat), 64'd28);
        check("busy_ign_lo",  64'(bus32.lo), 64'd30);
        check("busy_ign_hi",  64'(bus32.hi), 64'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus32.done) nd++;
        end
        check("busy_ign_nodone", 64'(nd), 64'd0);

        go32(1'b1, 32'd3, 32'd4);
        wait32(lat);
        check("b2b_first_lo", 64'(bus32.lo), 64'd12);
        bus32.start = 1'b1; bus32.operand1 = 32'd100; bus32.operand2 = 32'd100;
        lat = 0;
        do begin
            @(negedge clock);
            bus32.start = 1'b0;
            lat++;
        end while (!bus32.done && lat < 200);
        check("b2b_lat", 64'(lat), 64'd34);
        check("b2b_lo",  64'(bus32.lo), 64'd10000);
        check("b2b_hi",  64'(bus32.hi), 64'd0);

        go32(1'b1, 32'd7, 32'hFFFFFFFD);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", 64'(bus32.busy), 64'd0);
        check("abort_done", 64'(bus32.done), 64'd0);
        check("abort_hi",   64'(bus32.hi),   64'd0);
        check("abort_lo",   64'(bus32.lo),   64'd0);
        reset = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus32.done) nd++;
        end
        check("abort_nodone", 64'(nd), 64'd0);

        reset = 1'b1; bus32.start = 1'b1; bus32.operand1 = 32'd9; bus32.operand2 = 32'd9;
        @(negedge clock);
        reset = 1'b0; bus32.start = 1'b0;
        check("rst_wins_busy", 64'(bus32.busy), 64'd0);
        @(negedge clock);
        check("rst_wins_idle", 64'(bus32.busy), 64'd0);

        mul8("w8_smin", 1'b1, 8'h80, 8'h80, 16'h4000);
        mul8("w8_uff",  1'b0, 8'hFF, 8'hFF, 16'hFE01);
        mul8("w8_sff",  1'b1, 8'hFF, 8'h7F, 16'hFF81);
        for (int i = 0; i < 2000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (i % 2 == 1)
                ref8 = 16'($signed({{8{a8[7]}}, a8}) * $signed({{8{b8[7]}}, b8}));
            else
                ref8 = 16'({8'd0, a8} * {8'd0, b8});
            mul8(i % 2 == 1 ? "w8_rand_s" : "w8_rand_u", i % 2 == 1, a8, b8, ref8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised, iterative radix-2 Booth multiplier with a start/done handshake and a per-operation signed/unsigned mode. It retires one Booth step per clock and returns the full 2×WIDTH product split into `hi`/`lo`. It sits beside the ALU as the multi-cycle multiply unit: the control FSM issues `start`, stalls on `busy`, and writes `hi`/`lo` back when `done` pulses.

## Interface
- `WIDTH`, default 32: operand width in bits; legal values are 4 and up. `hi` and `lo` are each WIDTH bits.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clock`.
- `start`  in  1  request a multiply; accepted only when `busy`=0.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- `operand1`  in  WIDTH  multiplicand; sampled at accept.
- `operand2`  in  WIDTH  multiplier; sampled at accept.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: `hi`/`lo` were updated on this edge.
- `hi`  out  WIDTH  upper half of the product.
- `lo`  out  WIDTH  lower half of the product.

## Operation
- States are IDLE and RUN. The iteration counter is ceil(log2(WIDTH+2)) bits wide.
- Operand extension: W1 = WIDTH+1.
  - `is_signed`=1: both operands are sign-extended to W1 bits.
  - `is_signed`=0: both operands are zero-extended to W1 bits.
  - Result: one datapath covers both modes.
- Internal registers:
  - Multiplicand M is W1+1 bits, sign-extended from the W1-bit operand.
  - Accumulator P is (W1+1) + W1 + 1 bits: upper half, multiplier, Booth guard bit.
  - The extra upper bit prevents overflow on ±M, for example the signed minimum × signed minimum case.
- On accept:
  - Upper half of P ← 0.
  - Multiplier field ← extended `operand2`.
  - Guard bit ← 0.
  - M ← extended `operand1`.
  - Counter ← 0.
  - State → RUN.
- Each RUN cycle performs one Booth step, chosen by the two LSBs of P {multiplier LSB, guard}:
  - 00 or 11: no add.
  - 01: upper half += M.
  - 10: upper half −= M.
  - Then P is arithmetic-shifted right by 1 (the MSB is replicated).
  - Counter increments.
- After W1 steps, product = P[2·W1 : 1], truncated to its low 2·WIDTH bits.
  - `hi` ← product[2·WIDTH−1 : WIDTH].
  - `lo` ← product[WIDTH−1 : 0].
  - `done` ← 1 and `busy` ← 0; state → IDLE.
- `hi`/`lo` hold their value until the next completion or reset. They never show partial results.
- `start` while `busy`=1 is ignored: no queuing, and the in-flight operands are not disturbed.
- Input changes after accept have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Reset asserted mid-operation:
  - Aborts the operation at that edge and returns all outputs to their reset values.
  - No `done` is produced for the aborted operation.
- Accept edge E is the edge where `start`=1 and `busy`=0 (with `reset`=0).
  - `busy`=1 from E through E+W1−1.
  - At edge E+W1: `done`=1 for exactly one cycle, `hi`/`lo` valid, `busy`=0.
- Latency is W1 = WIDTH+1 cycles (33 for WIDTH=32). Fixed and independent of the operand values.
- Back-to-back: `start` may be high in the cycle where `done`=1. It is accepted at the next edge. Maximum throughput is one result per W1+1 cycles.
- `start` and `reset` high on the same edge: reset wins.

## Test plan
- Signed: WIDTH=32, `is_signed`=1, 7 × −3 (0xFFFFFFFD) → `done` exactly 33 cycles after accept; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Mode split on the same operands 0xFFFFFFFF × 0xFFFFFFFF:
  - unsigned → `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - signed → `hi`=0x00000000, `lo`=0x00000001.
- Extremes, signed:
  - 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
  - 0x7FFFFFFF × 0x80000000 → `hi`=0xC0000000, `lo`=0x80000000.
- Handshake:
  - Pulse `start` with 5×6 signed, then re-assert `start` with 100×100 while `busy` → result is `lo`=30 and `hi`=0, and no second `done` follows.
  - Then issue 100×100 with `start` held high during the `done` cycle → the next `done` arrives 34 cycles after the first, with `lo`=10000.
- Reset mid-op: assert `reset` at cycle 10 of a run → next edge has `busy`=0, `done`=0, `hi`=`lo`=0, and no `done` follows.
- Parameter: WIDTH=8, random 1000 operand pairs in both modes against a reference product → exact match; latency 9 cycles every time.
